// File: rtl/hello_world_qsys_logger_pkg.sv
// rtl/hello_world_qsys_logger_pkg.sv - shared types and word layouts for the RAM event logger
// Purpose: FSM state encoding, record/head word field positions and word builders.
// Ports: none (package).
package hello_world_qsys_logger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_REC  = 2'd1,
        ST_WR_HEAD = 2'd2
    } state_e;

    // Record word: {code[31:24], ts[23:0]}
    localparam int REC_CODE_LSB  = 24;
    localparam int REC_TS_W      = 24;
    // Head word: {drop[31:16], 4'h0, ptr[11:0]}
    localparam int HEAD_DROP_LSB = 16;
    localparam int HEAD_PTR_W    = 12;

    function automatic logic [31:0] make_record(input logic [7:0] code, input logic [REC_TS_W-1:0] ts);
        return {code, ts};
    endfunction

    function automatic logic [31:0] make_head(input logic [15:0] drop, input logic [HEAD_PTR_W-1:0] ptr);
        return {drop, 4'h0, ptr};
    endfunction

endpackage

// File: rtl/hello_world_qsys_ram_logger_if.sv
// rtl/hello_world_qsys_ram_logger_if.sv - write-only port bundle toward the on-chip RAM s2 port
// Purpose: groups the RAM write bus; master drives it, slave (RAM) observes it.
// Signals: ram_address[11:0], ram_byteenable[3:0], ram_chipselect, ram_write,
//          ram_writedata[31:0], ram_clken.
interface hello_world_qsys_ram_logger_if;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;

    modport master (
        output ram_address, ram_byteenable, ram_chipselect,
        output ram_write, ram_writedata, ram_clken
    );

    modport slave (
        input ram_address, ram_byteenable, ram_chipselect,
        input ram_write, ram_writedata, ram_clken
    );
endinterface

// File: rtl/hello_world_qsys_logger_fifo.sv
// rtl/hello_world_qsys_logger_fifo.sv - synchronous event FIFO with wrap-bit pointers
// Purpose: DEPTH x W buffer between event capture and the RAM writer.
// Ports: clk, reset (sync, active-high), clear_i (sync flush), push_i/push_data_i,
//        pop_i/pop_data_o (first-word fall-through), full_o, empty_o.
module hello_world_qsys_logger_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;
    logic         do_push, do_pop;

    // Extra MSB distinguishes full (MSBs differ) from empty (all bits equal).
    assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o    = (wr_q == rd_q);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/hello_world_qsys_ram_logger.sv
// rtl/hello_world_qsys_ram_logger.sv - timestamps events and logs them into a circular RAM region
// Purpose: captures {code, ts} records into a FIFO and drains each as a record write plus a
//          head-word write (next pointer, drop count) for software to walk the log.
// Ports: clk, reset (sync, active-high), event_valid/event_code, clear, ram (RAM write bus,
//        master), wr_ptr (next log address), drop_count (saturating), busy.
module hello_world_qsys_ram_logger
    import hello_world_qsys_logger_pkg::*;
#(
    parameter logic [11:0] LOG_BASE   = 12'hE00,
    parameter int          LOG_WORDS  = 256,
    parameter logic [11:0] HEAD_ADDR  = 12'hFFF,
    parameter int          FIFO_DEPTH = 8,
    parameter int          TS_W       = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          event_valid,
    input  logic [7:0]                    event_code,
    input  logic                          clear,
    hello_world_qsys_ram_logger_if.master ram,
    output logic [11:0]                   wr_ptr,
    output logic [15:0]                   drop_count,
    output logic                          busy
);
    localparam logic [11:0] LOG_LAST = LOG_BASE + 12'(LOG_WORDS - 1);

    state_e      state_q, state_d;
    logic [TS_W-1:0] ts_q;
    logic [15:0] drop_q;
    logic [11:0] ptr_q, ptr_d, ptr_next;
    logic [11:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        wr_q, wr_d;

    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0] fifo_rdata;

    // Full is the registered flag, so a same-cycle pop never frees room for a push.
    assign fifo_push = event_valid && !fifo_full && !clear;

    hello_world_qsys_logger_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear),
        .push_i      (fifo_push),
        .push_data_i (make_record(event_code, ts_q[REC_TS_W-1:0])),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign ptr_next = (ptr_q == LOG_LAST) ? LOG_BASE : ptr_q + 12'd1;

    // state_q names the write currently on the bus; outputs for the next cycle are built here.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        addr_d   = '0;
        data_d   = '0;
        wr_d     = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            ST_WR_REC: begin
                ptr_d   = ptr_next;
                wr_d    = 1'b1;
                addr_d  = HEAD_ADDR;
                data_d  = make_head(drop_q, ptr_next);
                state_d = ST_WR_HEAD;
            end
            ST_IDLE, ST_WR_HEAD: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    wr_d     = 1'b1;
                    addr_d   = ptr_q;
                    data_d   = fifo_rdata;
                    state_d  = ST_WR_REC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= ST_IDLE;
            ptr_q   <= LOG_BASE;
            drop_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            if (event_valid && fifo_full && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    assign ram.ram_address    = addr_q;
    assign ram.ram_writedata  = data_q;
    assign ram.ram_write      = wr_q;
    assign ram.ram_chipselect = wr_q;
    assign ram.ram_byteenable = wr_q ? 4'hF : 4'h0;
    assign ram.ram_clken      = 1'b1;

    assign wr_ptr     = ptr_q;
    assign drop_count = drop_q;
    assign busy       = !fifo_empty || (state_q != ST_IDLE);

endmodule
